ir_hit_decoder: RTL and testbench
=================================

# ir_hit_decoder

Receives the demodulated IR receiver output (`hit_data`, idle high, active-low marks) and decodes pulse-width-encoded shot frames into an 8-bit shooter ID. Sits directly upstream of the APB bus-interface block: its `hit_id`/`HIT_INT` outputs feed the register file and the MSS GPI interrupt line. All logic runs on the fabric clock.

## Interface
- `CLK_DIV`, 100: PCLK cycles per width tick (1 µs at 100 MHz).
- `HDR_MIN`, 2000 / `HDR_MAX`, 3000: header mark window, ticks, inclusive.
- `ZERO_MIN`, 400 / `ZERO_MAX`, 800: bit-0 mark window, ticks, inclusive.
- `ONE_MIN`, 1000 / `ONE_MAX`, 1400: bit-1 mark window, ticks, inclusive.
- `SPACE_MAX`, 1000: longest legal inter-mark space, ticks.
- `PCLK` in 1: fabric clock; all logic rising-edge.
- `PRESET` in 1: synchronous, active-high reset.
- `hit_data` in 1: raw IR receiver output, asynchronous, mark = low.
- `hit_ack` in 1: single-cycle pulse from the bus interface; clears `HIT_INT` and `overrun`.
- `hit_id` out 8: last good shooter ID, MSB first on air.
- `hit_valid` out 1: one-cycle strobe when `hit_id` updates.
- `HIT_INT` out 1: sticky interrupt, set on good frame.
- `frame_err` out 1: one-cycle strobe on aborted frame.
- `overrun` out 1: sticky; good frame arrived while `HIT_INT` already set.

## Operation
- Input: 2-flop synchronizer, reset to 1. FSM uses synchronized value `s`; mark start = `s` 1→0, mark end = `s` 0→1.
- Prescaler: free-running counter, `tick` every `CLK_DIV` cycles. Width counter: 12 bits, cleared on each mark start/end, +1 per tick, saturates at 4095.
- States: IDLE, HDR, SPACE, BIT, DONE.
- IDLE: mark start → HDR. Marks already low at reset release are ignored until next falling edge.
- HDR: mark end with width in [HDR_MIN,HDR_MAX] → SPACE, bit count 0, shift reg 0; otherwise → IDLE + `frame_err`. Width exceeding HDR_MAX while still marking → IDLE + `frame_err` immediately.
- SPACE: width > SPACE_MAX → IDLE + `frame_err`. Mark start → BIT.
- BIT: mark end: width in ZERO window shifts 0, ONE window shifts 1, else → IDLE + `frame_err`. After the last bit → DONE, else → SPACE. Width > ONE_MAX while marking → IDLE + `frame_err`.
- DONE (one cycle): load `hit_id`, pulse `hit_valid`, set `HIT_INT`; if `HIT_INT` was 1 and `hit_ack` is 0 this cycle, set `overrun`. → IDLE.
- `hit_ack` clears `HIT_INT` and `overrun`. Simultaneous `hit_ack` and DONE: `HIT_INT` ends 1, `overrun` ends 0.
- Windows are inclusive; widths quantized ±1 tick (prescaler not phase-aligned to edges).

## Timing
- Reset values: `hit_id`=0, `hit_valid`=0, `HIT_INT`=0, `frame_err`=0, `overrun`=0, FSM=IDLE, counters 0.
- `PRESET` mid-frame discards the partial frame; no `frame_err`.
- Latency: `hit_valid`/`hit_id`/`HIT_INT` registered 4 PCLK edges after the `hit_data` rising edge ending the last mark (2 sync + transition + output register).
- `frame_err` registered 3 edges after the offending edge/width overflow is sampled.
- `hit_valid`, `frame_err` high exactly one cycle.

## Configuration
- `IR_PARITY_EN` defined: frame carries 9 data marks; 9th is even parity over the 8 ID bits. Parity mismatch in DONE → `frame_err` strobe, no `hit_valid`, `HIT_INT`/`hit_id` unchanged.
- Undefined: 8 data marks; DONE always reports the ID.

## Test plan
- Header 2500, ID 0xA5 (1=1200, 0=600, spaces 500 ticks) → `hit_id`=0xA5, one `hit_valid` cycle, `HIT_INT`=1 four PCLK edges after last rising edge.
- Header 1500 ticks → `frame_err` pulse, no `hit_valid`, FSM back to IDLE; following valid frame 0x3C decodes.
- Good frame 0x11, no ack, good frame 0x22 → `hit_id`=0x22, `overrun`=1; `hit_ack` → `HIT_INT`=0, `overrun`=0.
- Space of 1500 ticks after bit 3 → `frame_err`; bit mark of 900 ticks → `frame_err`.
- `hit_ack` in same cycle as DONE → `HIT_INT`=1, `overrun`=0; `PRESET` during bit 5 → all outputs 0, no `frame_err`.
- With `IR_PARITY_EN`: 0xA5 + parity 0 → valid; 0xA5 + parity 1 → `frame_err`, `hit_id` unchanged.

Source files
------------

// File: rtl/ir_hit_decoder.sv
// ir_hit_decoder: pulse-width IR shot-frame decoder producing an 8-bit shooter ID.
// Define IR_PARITY_EN to expect a 9th even-parity mark after the ID bits.
module ir_hit_decoder #(
   parameter int CLK_DIV   = 100,
   parameter int HDR_MIN   = 2000,
   parameter int HDR_MAX   = 3000,
   parameter int ZERO_MIN  = 400,
   parameter int ZERO_MAX  = 800,
   parameter int ONE_MIN   = 1000,
   parameter int ONE_MAX   = 1400,
   parameter int SPACE_MAX = 1000
) (
   input  logic       PCLK,
   input  logic       PRESET,
   input  logic       hit_data,
   input  logic       hit_ack,
   output logic [7:0] hit_id,
   output logic       hit_valid,
   output logic       HIT_INT,
   output logic       frame_err,
   output logic       overrun
);

`ifdef IR_PARITY_EN
   localparam int NBITS = 9;
`else
   localparam int NBITS = 8;
`endif
   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [11:0] L_HDR_MIN   = 12'(HDR_MIN);
   localparam logic [11:0] L_HDR_MAX   = 12'(HDR_MAX);
   localparam logic [11:0] L_ZERO_MIN  = 12'(ZERO_MIN);
   localparam logic [11:0] L_ZERO_MAX  = 12'(ZERO_MAX);
   localparam logic [11:0] L_ONE_MIN   = 12'(ONE_MIN);
   localparam logic [11:0] L_ONE_MAX   = 12'(ONE_MAX);
   localparam logic [11:0] L_SPACE_MAX = 12'(SPACE_MAX);
   localparam logic [3:0]  L_LAST      = 4'(NBITS - 1);
   localparam logic [PW-1:0] L_PRE_TOP = PW'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_SPACE,
      S_BIT,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_next;

   logic             r_s1;
   logic             r_s;
   logic             r_s_d;
   logic [1:0]       r_live;
   logic             r_armed;
   logic [PW-1:0]    r_pre;
   logic [11:0]      r_width;
   logic [3:0]       r_bitcnt;
   logic [NBITS-1:0] r_shift;
   logic [7:0]       r_hit_id;
   logic             r_hit_valid;
   logic             r_hit_int;
   logic             r_frame_err;
   logic             r_overrun;

   logic       w_tick;
   logic       w_fall;
   logic       w_rise;
   logic       w_in_hdr;
   logic       w_in_zero;
   logic       w_in_one;
   logic       w_abort;
   logic       w_shift;
   logic       w_bit;
   logic       w_hdr_ok;
   logic       w_good;
   logic       w_bad;
   logic       w_par_ok;
   logic [7:0] w_id;

   // r_live flushes the reset value out of the synchronizer before arming,
   // so a line already low at reset release cannot look like a mark start.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_s1    <= 1'b1;
         r_s     <= 1'b1;
         r_s_d   <= 1'b1;
         r_live  <= 2'b00;
         r_armed <= 1'b0;
      end else begin
         r_s1    <= hit_data;
         r_s     <= r_s1;
         r_s_d   <= r_s;
         r_live  <= {r_live[0], 1'b1};
         r_armed <= r_armed | (r_live[1] & r_s);
      end
   end

   assign w_fall = r_armed & r_s_d & ~r_s;
   assign w_rise = ~r_s_d & r_s;
   assign w_tick = (r_pre == L_PRE_TOP);

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_pre <= '0;
      end else if (w_tick) begin
         r_pre <= '0;
      end else begin
         r_pre <= r_pre + 1'b1;
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_width <= '0;
      end else if (w_fall | w_rise) begin
         r_width <= '0;
      end else if (w_tick && (r_width != 12'hFFF)) begin
         r_width <= r_width + 1'b1;
      end
   end

   assign w_in_hdr  = (r_width >= L_HDR_MIN) && (r_width <= L_HDR_MAX);
   assign w_in_zero = (r_width >= L_ZERO_MIN) && (r_width <= L_ZERO_MAX);
   assign w_in_one  = (r_width >= L_ONE_MIN) && (r_width <= L_ONE_MAX);

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next   = r_state;
      w_abort  = 1'b0;
      w_shift  = 1'b0;
      w_bit    = 1'b0;
      w_hdr_ok = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_fall) begin
               w_next = S_HDR;
            end
         end
         S_HDR: begin
            if (w_rise) begin
               if (w_in_hdr) begin
                  w_next   = S_SPACE;
                  w_hdr_ok = 1'b1;
               end else begin
                  w_next  = S_IDLE;
                  w_abort = 1'b1;
               end
            end else if (r_width > L_HDR_MAX) begin
               w_next  = S_IDLE;
               w_abort = 1'b1;
            end
         end
         S_SPACE: begin
            if (w_fall) begin
               w_next = S_BIT;
            end else if (r_width > L_SPACE_MAX) begin
               w_next  = S_IDLE;
               w_abort = 1'b1;
            end
         end
         S_BIT: begin
            if (w_rise) begin
               if (w_in_zero || w_in_one) begin
                  w_shift = 1'b1;
                  w_bit   = w_in_one;
                  w_next  = (r_bitcnt == L_LAST) ? S_DONE : S_SPACE;
               end else begin
                  w_next  = S_IDLE;
                  w_abort = 1'b1;
               end
            end else if (r_width > L_ONE_MAX) begin
               w_next  = S_IDLE;
               w_abort = 1'b1;
            end
         end
         S_DONE: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

`ifdef IR_PARITY_EN
   assign w_par_ok = ~^r_shift;
   assign w_id     = r_shift[8:1];
`else
   assign w_par_ok = 1'b1;
   assign w_id     = r_shift;
`endif

   always_comb begin
      w_good = 1'b0;
      w_bad  = 1'b0;
      if (r_state == S_DONE) begin
         w_good = w_par_ok;
         w_bad  = ~w_par_ok;
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_bitcnt <= '0;
         r_shift  <= '0;
      end else if (w_hdr_ok) begin
         r_bitcnt <= '0;
         r_shift  <= '0;
      end else if (w_shift) begin
         r_bitcnt <= r_bitcnt + 1'b1;
         r_shift  <= {r_shift[NBITS-2:0], w_bit};
      end
   end

   // A good frame wins over a same-cycle ack for HIT_INT; ack wins for overrun.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_hit_id    <= '0;
         r_hit_valid <= 1'b0;
         r_hit_int   <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_hit_valid <= w_good;
         r_frame_err <= w_abort | w_bad;
         if (w_good) begin
            r_hit_id <= w_id;
         end
         if (w_good) begin
            r_hit_int <= 1'b1;
         end else if (hit_ack) begin
            r_hit_int <= 1'b0;
         end
         if (hit_ack) begin
            r_overrun <= 1'b0;
         end else if (w_good && r_hit_int) begin
            r_overrun <= 1'b1;
         end
      end
   end

   assign hit_id    = r_hit_id;
   assign hit_valid = r_hit_valid;
   assign HIT_INT   = r_hit_int;
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;

endmodule

// File: tb/tb_ir_hit_decoder.sv
// tb_ir_hit_decoder: directed and random IR frames against a width-rule model.
// Tick windows are scaled down 50x so whole frames stay short.
module tb_ir_hit_decoder;

   localparam int DIV  = 2;
   localparam int HMIN = 40;
   localparam int HMAX = 60;
   localparam int ZMIN = 8;
   localparam int ZMAX = 16;
   localparam int OMIN = 20;
   localparam int OMAX = 28;
   localparam int SMAX = 20;
`ifdef IR_PARITY_EN
   localparam int NB = 9;
`else
   localparam int NB = 8;
`endif

   logic       PCLK = 1'b0;
   logic       PRESET = 1'b1;
   logic       hit_data = 1'b1;
   logic       hit_ack = 1'b0;
   logic [7:0] hit_id;
   logic       hit_valid;
   logic       HIT_INT;
   logic       frame_err;
   logic       overrun;

   int total = 0;
   int bad = 0;
   int nv = 0;
   int ne = 0;
   int fq[$];

   logic [7:0] m_id = 8'h00;
   logic       m_int = 1'b0;
   logic       m_ovr = 1'b0;

   ir_hit_decoder #(
      .CLK_DIV(DIV), .HDR_MIN(HMIN), .HDR_MAX(HMAX),
      .ZERO_MIN(ZMIN), .ZERO_MAX(ZMAX),
      .ONE_MIN(OMIN), .ONE_MAX(OMAX), .SPACE_MAX(SMAX)
   ) dut (
      .PCLK(PCLK),
      .PRESET(PRESET),
      .hit_data(hit_data),
      .hit_ack(hit_ack),
      .hit_id(hit_id),
      .hit_valid(hit_valid),
      .HIT_INT(HIT_INT),
      .frame_err(frame_err),
      .overrun(overrun)
   );

   always #5 PCLK = ~PCLK;

   always @(negedge PCLK) begin
      if (hit_valid) nv++;
      if (frame_err) ne++;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge PCLK);
   endtask

   // fq alternates mark, space, mark ... widths in ticks
   task automatic play(input int lim);
      for (int k = 0; k < fq.size() && k < lim; k++) begin
         if (k % 2 == 0) begin
            hit_data = 1'b0;
            cyc(fq[k] * DIV);
            hit_data = 1'b1;
         end else begin
            cyc(fq[k] * DIV);
         end
      end
   endtask

   // err: 1 short hdr, 2 long hdr, 3 long space, 4 gap mark, 5 long mark
   task automatic gen(input logic [7:0] id, input logic par, input int err,
                      input int pos, input bit rnd);
      logic [8:0] fb;
      int w;
      fb = {id, par};
      fq.delete();
      if (err == 1) begin fq.push_back(30); return; end
      if (err == 2) begin fq.push_back(70); return; end
      fq.push_back(rnd ? int'($urandom_range(57, 43)) : 50);
      for (int i = 0; i < NB; i++) begin
         if (err == 3 && i == pos) begin fq.push_back(30); return; end
         fq.push_back(rnd ? int'($urandom_range(17, 5)) : 10);
         if (err == 4 && i == pos) begin fq.push_back(18); return; end
         if (err == 5 && i == pos) begin fq.push_back(35); return; end
         if (fb[8-i]) w = rnd ? int'($urandom_range(26, 22)) : 24;
         else         w = rnd ? int'($urandom_range(14, 10)) : 12;
         fq.push_back(w);
      end
   endtask

   // Classifies the frame in fq from the width rules alone.
   function automatic int model(output logic [7:0] id);
      logic [8:0] sh;
      int n;
      int k;
      sh = '0;
      n = 0;
      id = '0;
      if (fq.size() == 0) return 0;
      if (fq[0] < HMIN || fq[0] > HMAX) return 0;
      k = 1;
      while (n < NB) begin
         if (k + 1 >= fq.size()) return 0;
         if (fq[k] > SMAX) return 0;
         if (fq[k+1] >= ZMIN && fq[k+1] <= ZMAX) sh = {sh[7:0], 1'b0};
         else if (fq[k+1] >= OMIN && fq[k+1] <= OMAX) sh = {sh[7:0], 1'b1};
         else return 0;
         n++;
         k += 2;
      end
      if (NB == 9) begin
         id = sh[8:1];
         if (^sh) return 0;
      end else begin
         id = sh[7:0];
      end
      return 1;
   endfunction

   task automatic run_frame(input string tag);
      int v0;
      int e0;
      int g;
      logic [7:0] eid;
      v0 = nv;
      e0 = ne;
      g = model(eid);
      play(fq.size());
      cyc(80);
      if (g != 0) begin
         if (m_int) m_ovr = 1'b1;
         m_int = 1'b1;
         m_id = eid;
      end
      chk({tag, "_valid_cnt"}, nv - v0, (g != 0) ? 1 : 0);
      chk({tag, "_err_cnt"}, ne - e0, (g != 0) ? 0 : 1);
      chk({tag, "_id"}, hit_id, m_id);
      chk({tag, "_int"}, HIT_INT, m_int);
      chk({tag, "_ovr"}, overrun, m_ovr);
   endtask

   task automatic ack();
      hit_ack = 1'b1;
      cyc(1);
      hit_ack = 1'b0;
      m_int = 1'b0;
      m_ovr = 1'b0;
      cyc(2);
   endtask

   initial begin
      int v0;
      int e0;
      int err;
      logic [7:0] id;

      cyc(4);
      PRESET = 1'b0;
      cyc(3);
      chk("rst_id", hit_id, 0);
      chk("rst_valid", hit_valid, 0);
      chk("rst_int", HIT_INT, 0);
      chk("rst_err", frame_err, 0);
      chk("rst_ovr", overrun, 0);

      gen(8'hA5, 1'b0, 0, 0, 1'b0);
      play(fq.size());
      cyc(3);
      chk("lat_early_valid", hit_valid, 0);
      chk("lat_early_int", HIT_INT, 0);
      cyc(1);
      chk("lat_valid", hit_valid, 1);
      chk("lat_id", hit_id, 8'hA5);
      chk("lat_int", HIT_INT, 1);
      cyc(1);
      chk("lat_pulse_end", hit_valid, 0);
      m_int = 1'b1;
      m_id = 8'hA5;
      cyc(20);
      ack();

      gen(8'h00, 1'b0, 1, 0, 1'b0);
      run_frame("short_hdr");
      gen(8'h3C, 1'b0, 0, 0, 1'b0);
      run_frame("after_err_3c");
      ack();

      gen(8'h11, ^8'h11, 0, 0, 1'b0);
      run_frame("f11");
      gen(8'h22, ^8'h22, 0, 0, 1'b0);
      run_frame("f22_ovr");
      ack();
      chk("ack_int", HIT_INT, 0);
      chk("ack_ovr", overrun, 0);

      gen(8'h5A, ^8'h5A, 3, 4, 1'b0);
      run_frame("long_space");
      gen(8'h5A, ^8'h5A, 4, 2, 1'b0);
      run_frame("gap_mark");

      gen(8'h77, ^8'h77, 0, 0, 1'b0);
      run_frame("f77");
      gen(8'h42, ^8'h42, 0, 0, 1'b0);
      play(fq.size());
      cyc(3);
      hit_ack = 1'b1;
      cyc(1);
      hit_ack = 1'b0;
      chk("simul_valid", hit_valid, 1);
      chk("simul_id", hit_id, 8'h42);
      chk("simul_int", HIT_INT, 1);
      chk("simul_ovr", overrun, 0);
      m_int = 1'b1;
      m_ovr = 1'b0;
      m_id = 8'h42;
      cyc(20);

      v0 = nv;
      e0 = ne;
      gen(8'hC3, ^8'hC3, 0, 0, 1'b0);
      play(12);
      hit_data = 1'b0;
      cyc(10);
      PRESET = 1'b1;
      cyc(2);
      PRESET = 1'b0;
      cyc(2);
      chk("prst_id", hit_id, 0);
      chk("prst_int", HIT_INT, 0);
      chk("prst_valid", hit_valid, 0);
      cyc(40);
      hit_data = 1'b1;
      cyc(60);
      chk("prst_no_err", ne - e0, 0);
      chk("prst_no_valid", nv - v0, 0);
      m_int = 1'b0;
      m_ovr = 1'b0;
      m_id = 8'h00;
      gen(8'h96, ^8'h96, 0, 0, 1'b0);
      run_frame("after_prst");

`ifdef IR_PARITY_EN
      gen(8'hA5, 1'b0, 0, 0, 1'b0);
      run_frame("par_good");
      gen(8'hA5, 1'b1, 0, 0, 1'b0);
      run_frame("par_bad");
      gen(8'h3C, 1'b1, 0, 0, 1'b0);
      run_frame("par_bad_3c");
`endif

      for (int i = 0; i < 30; i++) begin
         id = 8'($urandom);
         err = ($urandom_range(9, 0) > 5) ? int'($urandom_range(5, 1)) : 0;
         gen(id, ^id, err, int'($urandom_range(NB - 1, 0)), 1'b1);
         run_frame("rnd");
         if ($urandom_range(3, 0) == 0) ack();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
